// File: rtl/frame_writer.sv
// Packs the aligned pixel stream into fixed-length write bursts for the frame
// buffer, ping-ponging between two frame regions.
module frame_writer #(
   parameter int H_DISP    = 16,
   parameter int V_DISP    = 12,
   parameter int BURST_LEN = 8,
   parameter int ADDR_W    = 20
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [15:0]                  data_aligned,
   input  logic                         data_aligned_valid,
   input  logic                         data_aligned_vs,
   output logic                         in_ready,
   output logic                         wr_req,
   output logic [ADDR_W-1:0]            wr_addr,
   output logic [$clog2(BURST_LEN):0]   wr_len,
   input  logic                         wr_ack,
   output logic [15:0]                  wr_data,
   output logic                         wr_data_valid,
   output logic                         frame_sel,
   output logic                         frame_done,
   output logic                         overflow
);

   localparam int FRAME_PIX = H_DISP * V_DISP;
   localparam int FIFO_D    = 2 * BURST_LEN;
   localparam int PTR_W     = $clog2(FIFO_D);
   localparam int CNT_W     = PTR_W + 1;
   localparam int LEN_W     = $clog2(BURST_LEN) + 1;
   localparam int PIX_W     = $clog2(FRAME_PIX + 1);

   localparam logic [PIX_W-1:0]  FRAME_N = PIX_W'(FRAME_PIX);
   localparam logic [CNT_W-1:0]  FIFO_N  = CNT_W'(FIFO_D);
   localparam logic [CNT_W-1:0]  BURST_N = CNT_W'(BURST_LEN);
   localparam logic [LEN_W-1:0]  BURST_L = LEN_W'(BURST_LEN);
   localparam logic [ADDR_W-1:0] BASE_1  = ADDR_W'(FRAME_PIX);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_BURST, S_FLUSH} state_t;

   state_t              r_state;
   logic [15:0]         r_mem [FIFO_D];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;
   logic [PIX_W-1:0]    r_pix_cnt;
   logic [PIX_W-1:0]    r_burst_ptr;
   logic [LEN_W-1:0]    r_beats;
   logic                r_pending_vs;
   logic                r_wr_req;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [LEN_W-1:0]    r_wr_len;
   logic [15:0]         r_wr_data;
   logic                r_wr_data_valid;
   logic                r_frame_sel;
   logic                r_frame_done;
   logic                r_overflow;

   logic                w_in_ready;
   logic                w_frame_end;
   logic                w_vs_flush;
   logic                w_push;
   logic                w_pop;
   logic [CNT_W-1:0]    w_count_nxt;
   logic [ADDR_W-1:0]   w_base;

   assign w_in_ready  = (r_count != FIFO_N) && !r_pending_vs && (r_pix_cnt < FRAME_N);
   assign w_frame_end = (r_state == S_BURST) && (r_beats == '0) && (r_burst_ptr == FRAME_N);
   assign w_pop       = ((r_state == S_REQ) && wr_ack) || ((r_state == S_BURST) && (r_beats != '0));
   assign w_push      = data_aligned_valid && w_in_ready && !w_vs_flush;
   assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
   assign w_base      = r_frame_sel ? BASE_1 : '0;

   // A frame start only forces a flush when something of the old frame is in flight;
   // a frame that completes on this very cycle with nothing buffered needs none.
   always_comb begin
      w_vs_flush = 1'b0;
      if (data_aligned_vs && !r_pending_vs) begin
         case (r_state)
            S_IDLE:  w_vs_flush = (r_burst_ptr != '0) || (r_count != '0);
            S_REQ:   w_vs_flush = 1'b1;
            S_BURST: w_vs_flush = !(w_frame_end && (r_count == '0));
            default: w_vs_flush = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= data_aligned;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state         <= S_IDLE;
         r_wr_ptr        <= '0;
         r_rd_ptr        <= '0;
         r_count         <= '0;
         r_pix_cnt       <= '0;
         r_burst_ptr     <= '0;
         r_beats         <= '0;
         r_pending_vs    <= 1'b0;
         r_wr_req        <= 1'b0;
         r_wr_addr       <= '0;
         r_wr_len        <= '0;
         r_wr_data       <= '0;
         r_wr_data_valid <= 1'b0;
         r_frame_sel     <= 1'b0;
         r_frame_done    <= 1'b0;
         r_overflow      <= 1'b0;
      end else begin
         r_frame_done    <= 1'b0;
         r_wr_data_valid <= w_pop;
         r_count         <= w_count_nxt;
         if (w_push) begin
            r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
            r_pix_cnt <= r_pix_cnt + PIX_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
            r_wr_data <= r_mem[r_rd_ptr];
         end
         if (data_aligned_valid && !w_push) r_overflow <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (w_vs_flush) begin
                  r_pending_vs <= 1'b1;
                  r_state      <= S_FLUSH;
               end else if (r_count >= BURST_N) begin
                  r_wr_req  <= 1'b1;
                  r_wr_addr <= w_base + ADDR_W'(r_burst_ptr);
                  r_wr_len  <= BURST_L;
                  r_state   <= S_REQ;
               end else if ((r_pix_cnt == FRAME_N) && (r_count != '0)) begin
                  r_wr_req  <= 1'b1;
                  r_wr_addr <= w_base + ADDR_W'(r_burst_ptr);
                  r_wr_len  <= LEN_W'(r_count);
                  r_state   <= S_REQ;
               end
            end
            S_REQ: begin
               if (w_vs_flush) r_pending_vs <= 1'b1;
               // the first word is popped on the accepting edge so it appears right after ack
               if (wr_ack) begin
                  r_wr_req    <= 1'b0;
                  r_burst_ptr <= r_burst_ptr + PIX_W'(r_wr_len);
                  r_beats     <= r_wr_len - LEN_W'(1);
                  r_state     <= S_BURST;
               end
            end
            S_BURST: begin
               if (w_vs_flush) r_pending_vs <= 1'b1;
               if (r_beats != '0) begin
                  r_beats <= r_beats - LEN_W'(1);
               end else begin
                  if (w_frame_end) begin
                     r_frame_done <= 1'b1;
                     r_frame_sel  <= ~r_frame_sel;
                     r_burst_ptr  <= '0;
                     r_pix_cnt    <= '0;
                  end
                  r_state <= (r_pending_vs || w_vs_flush) ? S_FLUSH : S_IDLE;
               end
            end
            S_FLUSH: begin
               r_wr_ptr     <= '0;
               r_rd_ptr     <= '0;
               r_count      <= '0;
               r_pix_cnt    <= '0;
               r_burst_ptr  <= '0;
               r_pending_vs <= 1'b0;
               r_state      <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready      = w_in_ready;
   assign wr_req        = r_wr_req;
   assign wr_addr       = r_wr_addr;
   assign wr_len        = r_wr_len;
   assign wr_data       = r_wr_data;
   assign wr_data_valid = r_wr_data_valid;
   assign frame_sel     = r_frame_sel;
   assign frame_done    = r_frame_done;
   assign overflow      = r_overflow;

endmodule

// File: tb/tb_frame_writer.sv
// Scoreboard bench for frame_writer: a 16x12 instance for the main scenarios and
// a 10x3 instance for the tail-burst case.
module tb_frame_writer;

   localparam int AW = 20;
   localparam int LW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, din_v, vs, wr_ack, in_ready, wr_req, wr_data_valid;
   logic          frame_sel, frame_done, overflow;
   logic [15:0]   din, wr_data;
   logic [AW-1:0] wr_addr;
   logic [LW-1:0] wr_len;

   logic          s_rst_n, s_din_v, s_vs, s_wr_ack, s_in_ready, s_wr_req, s_wr_data_valid;
   logic          s_frame_sel, s_frame_done, s_overflow;
   logic [15:0]   s_din, s_wr_data;
   logic [AW-1:0] s_wr_addr;
   logic [LW-1:0] s_wr_len;

   frame_writer #(.H_DISP(16), .V_DISP(12), .BURST_LEN(8), .ADDR_W(AW)) u_dut (
      .clk(clk), .rst_n(rst_n), .data_aligned(din), .data_aligned_valid(din_v),
      .data_aligned_vs(vs), .in_ready(in_ready), .wr_req(wr_req), .wr_addr(wr_addr),
      .wr_len(wr_len), .wr_ack(wr_ack), .wr_data(wr_data), .wr_data_valid(wr_data_valid),
      .frame_sel(frame_sel), .frame_done(frame_done), .overflow(overflow)
   );

   frame_writer #(.H_DISP(10), .V_DISP(3), .BURST_LEN(8), .ADDR_W(AW)) u_small (
      .clk(clk), .rst_n(s_rst_n), .data_aligned(s_din), .data_aligned_valid(s_din_v),
      .data_aligned_vs(s_vs), .in_ready(s_in_ready), .wr_req(s_wr_req), .wr_addr(s_wr_addr),
      .wr_len(s_wr_len), .wr_ack(s_wr_ack), .wr_data(s_wr_data), .wr_data_valid(s_wr_data_valid),
      .frame_sel(s_frame_sel), .frame_done(s_frame_done), .overflow(s_overflow)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] q_req[$];
   logic [15:0] q_dat[$];
   logic [31:0] s_q_req[$];
   logic [15:0] s_q_dat[$];
   int words = 0, dones = 0, s_words = 0, s_dones = 0;
   bit hold = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pk(input int a, input int l);
      return {8'd0, 20'(a), 4'(l)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Main monitor: every new request and every burst word is checked against the queues.
   initial begin
      bit seen;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            seen = 1'b0;
         end else begin
            if (wr_req && !seen) begin
               seen = 1'b1;
               if (q_req.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL req_extra: got addr %0d len %0d, expected no request", wr_addr, wr_len);
               end else begin
                  check("req_addr_len", {8'd0, wr_addr, wr_len}, q_req.pop_front());
               end
            end else if (!wr_req) begin
               seen = 1'b0;
            end
            if (wr_data_valid) begin
               words++;
               if (q_dat.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL data_extra: got %0h, expected no word", wr_data);
               end else begin
                  check("wr_data", 32'(wr_data), 32'(q_dat.pop_front()));
               end
            end
            if (frame_done) dones++;
         end
      end
   end

   initial begin
      bit seen;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         if (s_rst_n) begin
            if (s_wr_req && !seen) begin
               seen = 1'b1;
               if (s_q_req.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL small_req_extra: got addr %0d len %0d, expected no request", s_wr_addr, s_wr_len);
               end else begin
                  check("small_req_addr_len", {8'd0, s_wr_addr, s_wr_len}, s_q_req.pop_front());
               end
            end else if (!s_wr_req) begin
               seen = 1'b0;
            end
            if (s_wr_data_valid) begin
               s_words++;
               if (s_q_dat.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL small_data_extra: got %0h, expected no word", s_wr_data);
               end else begin
                  check("small_wr_data", 32'(s_wr_data), 32'(s_q_dat.pop_front()));
               end
            end
            if (s_frame_done) begin
               s_dones++;
               check("small_done_after_word30", s_words, 30);
            end
         end
      end
   end

   // Ack responders: ack two cycles after the request is seen, unless held off.
   initial begin
      int wcnt;
      wcnt = 0;
      wr_ack = 1'b0;
      forever begin
         tick();
         if (wr_ack) wr_ack = 1'b0;
         else if (wr_req && !hold) begin
            if (wcnt >= 1) begin wr_ack = 1'b1; wcnt = 0; end
            else wcnt++;
         end else wcnt = 0;
      end
   end

   initial begin
      int wcnt;
      wcnt = 0;
      s_wr_ack = 1'b0;
      forever begin
         tick();
         if (s_wr_ack) s_wr_ack = 1'b0;
         else if (s_wr_req) begin
            if (wcnt >= 1) begin s_wr_ack = 1'b1; wcnt = 0; end
            else wcnt++;
         end else wcnt = 0;
      end
   end

   task automatic pix(input logic [15:0] v);
      tick(); din = v; din_v = 1'b1;
      tick(); din_v = 1'b0;
   endtask

   task automatic pulse_vs();
      tick(); vs = 1'b1;
      tick(); vs = 1'b0;
   endtask

   task automatic wait_words(input int target, input string name);
      int k = 0;
      while (words < target && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check(name, words, target);
   endtask

   task automatic run_frame(input int base, input logic [15:0] tag, input string name);
      int w0;
      w0 = words;
      for (int b = 0; b < 24; b++) q_req.push_back(pk(base + 8 * b, 8));
      pulse_vs();
      for (int i = 0; i < 192; i++) begin
         q_dat.push_back(tag + 16'(i));
         pix(tag + 16'(i));
      end
      wait_words(w0 + 192, name);
      repeat (3) tick();
      check({name, "_reqs_left"}, q_req.size(), 0);
   endtask

   task automatic run_main();
      int d0, w0, k;
      rst_n = 1'b0; din = '0; din_v = 1'b0; vs = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_wr_req", wr_req, 0);
      check("rst_wr_data_valid", wr_data_valid, 0);
      check("rst_frame_sel", frame_sel, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_overflow", overflow, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_wr_addr", wr_addr, 0);
      tick(); rst_n = 1'b1;

      d0 = dones;
      run_frame(0, 16'hA000, "f1_words");
      check("f1_done_count", dones - d0, 1);
      check("f1_frame_sel", frame_sel, 1);
      check("f1_overflow", overflow, 0);

      // FIFO fills while the controller withholds ack
      q_req.push_back(pk(192, 8));
      q_req.push_back(pk(200, 8));
      hold = 1'b1;
      pulse_vs();
      for (int i = 0; i < 30; i++) begin
         tick(); din = 16'hB000 + 16'(i); din_v = 1'b1;
         if (i < 16) q_dat.push_back(16'hB000 + 16'(i));
      end
      tick(); din_v = 1'b0;
      repeat (10) tick();
      @(negedge clk);
      check("ovf_overflow", overflow, 1);
      check("ovf_in_ready", in_ready, 0);
      check("ovf_req_held", wr_req, 1);
      w0 = words;
      hold = 1'b0;
      wait_words(w0 + 16, "ovf_words");
      repeat (3) tick();
      check("ovf_reqs_left", q_req.size(), 0);

      // frame start with a request in flight
      d0 = dones;
      w0 = words;
      pulse_vs();
      for (int b = 0; b < 6; b++) q_req.push_back(pk(192 + 8 * b, 8));
      for (int i = 0; i < 40; i++) begin
         q_dat.push_back(16'hC000 + 16'(i));
         pix(16'hC000 + 16'(i));
      end
      wait_words(w0 + 40, "vs_words_a");
      repeat (4) tick();
      hold = 1'b1;
      for (int i = 40; i < 50; i++) begin
         if (i < 48) q_dat.push_back(16'hC000 + 16'(i));
         pix(16'hC000 + 16'(i));
      end
      k = 0;
      while (!wr_req && k < 100) begin tick(); k++; end
      check("vs_req_pending", wr_req, 1);
      pulse_vs();
      hold = 1'b0;
      wait_words(w0 + 48, "vs_words_b");
      repeat (4) tick();
      check("vs_no_frame_done", dones - d0, 0);
      check("vs_frame_sel_kept", frame_sel, 1);
      q_req.push_back(pk(192, 8));
      for (int i = 0; i < 8; i++) begin
         q_dat.push_back(16'hD000 + 16'(i));
         pix(16'hD000 + 16'(i));
      end
      wait_words(w0 + 56, "vs_words_c");
      repeat (3) tick();
      check("vs_reqs_left", q_req.size(), 0);

      // reset asserted during the 4th word of a burst
      q_req.push_back(pk(200, 8));
      w0 = words;
      for (int i = 0; i < 8; i++) begin
         q_dat.push_back(16'hE000 + 16'(i));
         pix(16'hE000 + 16'(i));
      end
      k = 0;
      while (words < w0 + 4 && k < 200) begin
         @(negedge clk); #2;
         k++;
      end
      check("mid_rst_word4", words, w0 + 4);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_wr_data_valid", wr_data_valid, 0);
      check("mid_rst_wr_req", wr_req, 0);
      check("mid_rst_frame_sel", frame_sel, 0);
      check("mid_rst_overflow", overflow, 0);
      check("mid_rst_in_ready", in_ready, 1);
      q_dat.delete();
      q_req.delete();
      tick(); rst_n = 1'b1;

      d0 = dones;
      run_frame(0, 16'h1000, "c1_words");
      check("c1_frame_sel", frame_sel, 1);
      run_frame(192, 16'h2000, "c2_words");
      check("c2_frame_sel", frame_sel, 0);
      check("c_done_count", dones - d0, 2);
      check("c_overflow", overflow, 0);
   endtask

   task automatic run_small();
      int k;
      s_rst_n = 1'b0; s_din = '0; s_din_v = 1'b0; s_vs = 1'b0;
      repeat (3) @(posedge clk);
      tick(); s_rst_n = 1'b1;
      s_q_req.push_back(pk(0, 8));
      s_q_req.push_back(pk(8, 8));
      s_q_req.push_back(pk(16, 8));
      s_q_req.push_back(pk(24, 6));
      tick(); s_vs = 1'b1;
      tick(); s_vs = 1'b0;
      for (int i = 0; i < 30; i++) begin
         s_q_dat.push_back(16'hF000 + 16'(i));
         tick(); s_din = 16'hF000 + 16'(i); s_din_v = 1'b1;
         tick(); s_din_v = 1'b0;
      end
      k = 0;
      while (s_words < 30 && k < 500) begin @(negedge clk); k++; end
      check("small_words", s_words, 30);
      repeat (4) tick();
      check("small_done_count", s_dones, 1);
      check("small_frame_sel", s_frame_sel, 1);
      check("small_reqs_left", s_q_req.size(), 0);
      check("small_overflow", s_overflow, 0);
   endtask

   initial begin
      fork
         run_main();
         run_small();
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: run did not complete, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

endmodule
